acc_block: RTL and testbench

ACC_BLOCK -- requirements
Module: acc_block

---
 rtl/acc_pkg.sv | 16 +
 rtl/addsub_sat.sv | 42 ++++
 rtl/acc_block.sv | 83 ++++++++
 tb/tb_acc_block.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared definitions for the block accumulator: the per-sample operation
// encoding and the width helper for the sample counter.
package acc_pkg;

    typedef enum logic [1:0] {
        MODE_LOAD = 2'd0,
        MODE_ADD  = 2'd1,
        MODE_SUB  = 2'd2
    } mode_e;

    // Counter width is max(1, clog2(depth)) so a single-sample block still has a port bit.
    function automatic int cnt_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/addsub_sat.sv
// Combinational load/add/subtract datapath with optional unsigned saturation.
// o_flag reports carry-out on add and borrow on subtract; it is never set on load.
module addsub_sat
    import acc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SAT   = 0
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  mode_e            i_mode,
    output logic [WIDTH-1:0] o_result,
    output logic             o_flag
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        // NOTE: both outputs get a default first so no path through the case can infer a latch.
        o_result = i_b;
        o_flag   = 1'b0;
        unique case (i_mode)
            MODE_ADD: begin
                o_flag   = w_sum[WIDTH];
                o_result = (SAT != 0 && w_sum[WIDTH]) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
            end
            MODE_SUB: begin
                o_flag   = w_diff[WIDTH];
                o_result = (SAT != 0 && w_diff[WIDTH]) ? {WIDTH{1'b0}} : w_diff[WIDTH-1:0];
            end
            default: begin
                o_result = i_b;
                o_flag   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/acc_block.sv
// Block accumulator: sums DEPTH enabled samples per block and pulses q_valid
// with the result; acc=0 turns it into a plain enabled load register.
module acc_block
    import acc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SAT   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       acc,
    input  logic                       sub,
    input  logic [WIDTH-1:0]           d,
    output logic [WIDTH-1:0]           q,
    output logic                       q_valid,
    output logic                       ovf,
    output logic [cnt_w(DEPTH)-1:0]    cnt
);

    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;

    logic             w_first;
    logic             w_last;
    mode_e            w_mode;
    logic [WIDTH-1:0] w_result;
    logic             w_flag;

    // A sample at cnt==0 opens a new block, so it loads instead of combining.
    assign w_first = (r_cnt == '0);
    assign w_last  = (r_cnt == CW'(DEPTH - 1));
    assign w_mode  = (!acc || w_first) ? MODE_LOAD : (sub ? MODE_SUB : MODE_ADD);

    addsub_sat #(
        .WIDTH (WIDTH),
        .SAT   (SAT)
    ) u_addsub (
        .i_a      (r_q),
        .i_b      (d),
        .i_mode   (w_mode),
        .o_result (w_result),
        .o_flag   (w_flag)
    );

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= '0;
            r_q_valid <= 1'b0;
            r_ovf     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_q_valid <= 1'b0;
            if (en) begin
                r_q <= w_result;
                if (!acc) begin
                    r_cnt <= '0;
                    r_ovf <= 1'b0;
                end else begin
                    r_ovf <= w_first ? 1'b0 : (r_ovf | w_flag);
                    if (w_last) begin
                        r_cnt     <= '0;
                        r_q_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign q       = r_q;
    assign q_valid = r_q_valid;
    assign ovf     = r_ovf;
    assign cnt     = r_cnt;

endmodule

// File: tb/tb_acc_block.sv
// Self-checking bench: a wrap-around and a saturating acc_block share stimulus
// and are compared against an arithmetic reference model every cycle.
module tb_acc_block;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 2;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en  = 1'b0;
    logic             acc = 1'b0;
    logic             sub = 1'b0;
    logic [WIDTH-1:0] d   = '0;

    logic [WIDTH-1:0] q_w, q_s;
    logic             qv_w, qv_s, ovf_w, ovf_s;
    logic [CW-1:0]    cnt_w, cnt_s;

    int n_total = 0;
    int n_bad   = 0;

    // Reference state, index 0 = wrap-around instance, 1 = saturating instance.
    int m_q[2];
    int m_cnt[2];
    int m_ovf[2];
    int m_qv[2];

    always #5 clk = ~clk;

    acc_block #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .acc(acc), .sub(sub), .d(d),
        .q(q_w), .q_valid(qv_w), .ovf(ovf_w), .cnt(cnt_w)
    );

    acc_block #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .acc(acc), .sub(sub), .d(d),
        .q(q_s), .q_valid(qv_s), .ovf(ovf_s), .cnt(cnt_s)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock of the specified behaviour, expressed as whole-number arithmetic.
    task automatic model_step(input bit r, input bit e, input bit a, input bit sb, input int dv);
        for (int s = 0; s < 2; s++) begin
            if (r) begin
                m_q[s] = 0; m_cnt[s] = 0; m_ovf[s] = 0; m_qv[s] = 0;
            end else begin
                m_qv[s] = 0;
                if (e) begin
                    if (!a) begin
                        m_q[s] = dv; m_cnt[s] = 0; m_ovf[s] = 0;
                    end else begin
                        if (m_cnt[s] == 0) begin
                            m_q[s]   = dv;
                            m_ovf[s] = 0;
                        end else begin
                            int v;
                            v = sb ? (m_q[s] - dv) : (m_q[s] + dv);
                            if (v < 0 || v > MAXV) m_ovf[s] = 1;
                            if (s == 1) v = (v < 0) ? 0 : ((v > MAXV) ? MAXV : v);
                            else        v = v & MAXV;
                            m_q[s] = v;
                        end
                        if (m_cnt[s] == DEPTH - 1) begin
                            m_cnt[s] = 0;
                            m_qv[s]  = 1;
                        end else begin
                            m_cnt[s] = m_cnt[s] + 1;
                        end
                    end
                end
            end
        end
    endtask

    // Apply inputs, clock once, then compare both instances with the model.
    task automatic step(input bit r, input bit e, input bit a, input bit sb, input int dv);
        rst = r; en = e; acc = a; sub = sb; d = WIDTH'(dv);
        @(posedge clk);
        model_step(r, e, a, sb, dv);
        #1;
        check("wrap_q",   int'(q_w),   m_q[0]);
        check("wrap_cnt", int'(cnt_w), m_cnt[0]);
        check("wrap_ovf", int'(ovf_w), m_ovf[0]);
        check("wrap_qv",  int'(qv_w),  m_qv[0]);
        check("sat_q",    int'(q_s),   m_q[1]);
        check("sat_cnt",  int'(cnt_s), m_cnt[1]);
        check("sat_ovf",  int'(ovf_s), m_ovf[1]);
        check("sat_qv",   int'(qv_s),  m_qv[1]);
    endtask

    task automatic acc_step(input int dv, input int exp_q, input int exp_cnt, input int exp_qv);
        step(1'b0, 1'b1, 1'b1, 1'b0, dv);
        check("dir_q",   int'(q_w),   exp_q);
        check("dir_cnt", int'(cnt_w), exp_cnt);
        check("dir_qv",  int'(qv_w),  exp_qv);
    endtask

    initial begin
        int blk_q_w[4];
        int blk_q_s[4];
        int blk_d[4];

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 0);
        check("rst_q", int'(q_w), 0);

        // Simple block: 10,20,30,40
        acc_step(10, 10, 1, 0);
        acc_step(20, 30, 2, 0);
        acc_step(30, 60, 3, 0);
        acc_step(40, 100, 0, 1);
        check("blk1_ovf", int'(ovf_w), 0);

        // Overflow block: wrap vs saturate
        blk_d   = '{200, 100, 1, 1};
        blk_q_w = '{200, 44, 45, 46};
        blk_q_s = '{200, 255, 255, 255};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, blk_d[i]);
            check("ovfblk_wq", int'(q_w), blk_q_w[i]);
            check("ovfblk_sq", int'(q_s), blk_q_s[i]);
            check("ovfblk_ovf", int'(ovf_w), (i == 0) ? 0 : 1);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 7);
        check("newblk_ovf_clear", int'(ovf_w), 0);

        // Underflow: 5 then minus 7
        step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 5);
        step(1'b0, 1'b1, 1'b1, 1'b1, 7);
        check("under_wq", int'(q_w), 254);
        check("under_sq", int'(q_s), 0);
        check("under_ovf", int'(ovf_s), 1);

        // Enable gap between samples 2 and 3
        step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        acc_step(1, 1, 1, 0);
        acc_step(2, 3, 2, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 99);
            check("hold_q", int'(q_w), 3);
            check("hold_cnt", int'(cnt_w), 2);
        end
        acc_step(3, 6, 3, 0);
        acc_step(4, 10, 0, 1);

        // Abort mid-block with a plain load, then reset with en high
        acc_step(200, 200, 1, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 100);
        step(1'b0, 1'b1, 1'b0, 1'b0, 'h5A);
        check("abort_q", int'(q_w), 'h5A);
        check("abort_cnt", int'(cnt_w), 0);
        check("abort_ovf", int'(ovf_w), 0);
        check("abort_qv", int'(qv_w), 0);
        acc_step(9, 9, 1, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 77);
        check("rst_en_q", int'(q_w), 0);

        // Reset pulse between edges must be ignored
        acc_step(33, 33, 1, 0);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("async_rst_ignored_q", int'(q_w), 33);

        // Back-to-back blocks
        step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, (i < 4) ? 1 : 2);
            if (i == 3) begin
                check("b2b_q1", int'(q_w), 4);
                check("b2b_qv1", int'(qv_w), 1);
            end
            if (i == 7) begin
                check("b2b_q2", int'(q_w), 8);
                check("b2b_qv2", int'(qv_w), 1);
            end
        end

        // Randomized traffic with boundary-biased samples
        for (int i = 0; i < 800; i++) begin
            int dv;
            int pick;
            pick = int'($urandom_range(0, 9));
            if (pick == 0)      dv = 0;
            else if (pick == 1) dv = MAXV;
            else                dv = int'($urandom_range(0, MAXV));
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 6) != 0), $urandom_range(0, 1) == 1, dv);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
